uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Transmit holding FIFO that sits directly upstream of the async UART transmitter when its TX_FIFO mode is enabled.
- Accepts bytes from the APB register interface and presents them to the transmitter through an active-low read strobe and an empty flag.
- Reports full/almost-full/count status and a sticky overflow flag back to the register file.

Parameters:
- DATA_W, 8, width of each stored byte.
- ADDR_W, 4, pointer width; depth = 2**ADDR_W (16 entries).
- AFULL_LVL, 12, occupancy at or above which afull asserts.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe from APB side, one byte per high cycle.
- wr_data  in  DATA_W  byte to store.
- rd_en_n  in  1  active-low read strobe from transmitter, one pop per low cycle.
- rd_data  out  DATA_W  registered head-of-queue byte popped by the last accepted read.
- empty  out  1  high when occupancy = 0; drives the transmitter's FIFO-empty input.
- full  out  1  high when occupancy = 2**ADDR_W.
- afull  out  1  high when occupancy >= AFULL_LVL.
- count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- overflow  out  1  sticky, set by a dropped write.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
Reset:
- Clock is clk; reset is asynchronous, active-high.
- On reset: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, empty=1, full=0, afull=0, overflow=0.
- Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately, with no wait for a clock edge.

Write:
- Accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle).
- mem[wr_ptr] <= wr_data; wr_ptr increments modulo 2**ADDR_W (natural wrap of ADDR_W bits).

Read:
- Accepted when rd_en_n=0 and empty=0.
- rd_data <= mem[rd_ptr] on that edge; rd_ptr increments with wrap.
- Latency: data valid on rd_data the cycle after the strobe is sampled, and held until the next accepted read.
- The transmitter samples rd_data at least two cycles after its strobe, so this latency is sufficient.

Reads and writes in the same cycle:
- When empty=1: the write is accepted, the read is ignored, rd_data is unchanged, and count becomes 1. No fall-through: the new byte is not visible on rd_data that cycle.
- When full=1: both are accepted; count stays at 2**ADDR_W and full stays 1.
- Otherwise both are accepted and count is unchanged.

Count and flags:
- count is a registered up/down counter: +1 on write-only, -1 on read-only.
- empty, full and afull are registered, derived from the next-state count, so they update in the same edge as count.

Boundary conditions:
- Write while full with no read: byte dropped, pointers unchanged, overflow <= 1.
- overflow stays set until clr_ovf=1. If clr_ovf and a dropped write occur in the same cycle, set wins.
- Read while empty: ignored; no pointer change, rd_data holds, no error flag.
- rd_en_n held low for several cycles: one pop per cycle until empty.

Optional Feature:
- Macro: UART_TX_FIFO_FLUSH_EN.
- When defined: adds input port flush (1 bit, active-high, synchronous).
- On a flush cycle: wr_ptr, rd_ptr and count go to 0, empty=1, full=0, afull=0. Any write or read in that cycle is ignored. rd_data and overflow are unaffected.
- When undefined: no flush port exists, and pointers clear only on reset.

Test Plan:
- Reset, then idle: empty=1, full=0, count=0, rd_data=0x00, overflow=0.
- Write 0xA5, 0x3C; pulse rd_en_n low twice (one cycle each, gap of 3): rd_data=0xA5 one cycle after the first pulse and 0x3C one cycle after the second; empty=1 after the second pop; count sequence 1,2,1,0.
- Write 16 bytes 0x00..0x0F: afull asserts when count reaches 12, full=1 at 16. A 17th write of 0xFF is dropped and overflow=1. Drain all 16 bytes: values 0x00..0x0F in order (pointer wrap verified on a second fill of 0x10..0x1F).
- With full=1, assert wr_en (0x77) and rd_en_n=0 together: rd_data gets the head byte, count stays 16, and 0x77 is read last.
- With empty=1, assert wr_en (0x5A) and rd_en_n=0 together: rd_data unchanged, count=1, empty=0. A next-cycle read returns 0x5A.
- Assert reset asynchronously mid-fill (count=7) between clock edges: all outputs return to reset values before the next edge. With UART_TX_FIFO_FLUSH_EN, a flush at count=9 gives count=0 and empty=1 on the next edge, with overflow preserved.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO between the APB register file and the UART transmitter.
// Optional synchronous flush port enabled by defining UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_n,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;

    logic flush_c;
    logic rd_acc_c;
    logic wr_acc_c;
    logic drop_c;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Accept decisions; a read frees a slot for a same-cycle write when full.
    always_comb begin
        rd_acc_c = !rd_en_n && !empty_q && !flush_c;
        wr_acc_c = wr_en && (!full_q || rd_acc_c) && !flush_c;
        drop_c   = wr_en && full_q && !rd_acc_c && !flush_c;
    end

    // Next-state pointers, counter, read data and flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        ovf_d     = ovf_q;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            rd_data_d = mem[rd_ptr_q];
        end

        case ({wr_acc_c, rd_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A dropped write beats a same-cycle clear.
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        afull_d = (count_d >= CNT_W'(AFULL_LVL));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign afull    = afull_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo; the flush scenario runs only when
// UART_TX_FIFO_FLUSH_EN is defined.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en_n;
    logic       flush;
    logic       clr_ovf;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       afull;
    logic [4:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];
    int         mcount;
    logic [7:0] exp_rd;
    logic       exp_ovf;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en_n  (rd_en_n),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .afull    (afull),
        .count    (count),
        .overflow (overflow)
    );

    // One clock of stimulus; updates the scoreboard/model, outputs sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic rdn, input logic clr);
        bit racc;
        bit wacc;
        racc = !rdn && (mcount > 0);
        wacc = w && ((mcount < 16) || racc);
        wr_en   = w;
        wr_data = d;
        rd_en_n = rdn;
        clr_ovf = clr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en_n = 1'b1;
        clr_ovf = 1'b0;
        if (racc) exp_rd = sb.pop_front();
        if (wacc) sb.push_back(d);
        mcount = mcount + int'(wacc) - int'(racc);
        if (w && !wacc) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
    endtask

    task automatic model_clear();
        sb.delete();
        mcount  = 0;
        exp_rd  = 8'h00;
        exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if ({empty, full, afull, overflow} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got e/f/af/ovf=%b want 1000", {empty, full, afull, overflow});
        end
        n_checks++;
        if (count !== 5'd0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_count_data: got count=%0d rd_data=%h want 0/00", count, rd_data);
        end
    endtask

    task automatic test_basic();
        logic [4:0] cseq[4];
        int k;
        k = 0;
        cyc(1'b1, 8'hA5, 1'b1, 1'b0); cseq[k++] = count;
        cyc(1'b1, 8'h3C, 1'b1, 1'b0); cseq[k++] = count;
        cyc(1'b0, 8'h00, 1'b0, 1'b0); cseq[k++] = count;
        n_checks++;
        if (rd_data !== 8'hA5 || rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL basic_pop1: got %h want a5", rd_data);
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (rd_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_hold: got %h want a5", rd_data);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0); cseq[k++] = count;
        n_checks++;
        if (rd_data !== 8'h3C || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pop2: got data=%h empty=%b want 3c/1", rd_data, empty);
        end
        n_checks++;
        if (cseq[0] !== 5'd1 || cseq[1] !== 5'd2 || cseq[2] !== 5'd1 || cseq[3] !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_count_seq: got %0d,%0d,%0d,%0d want 1,2,1,0",
                     cseq[0], cseq[1], cseq[2], cseq[3]);
        end
        // read while empty is ignored
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h3C || count !== 5'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_read: got data=%h count=%0d ovf=%b want 3c/0/0", rd_data, count, overflow);
        end
    endtask

    task automatic fill_drain(input logic [7:0] base);
        int bad_flags;
        int bad_data;
        bad_flags = 0;
        bad_data  = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, base + 8'(i), 1'b1, 1'b0);
            if (afull !== (i + 1 >= 12) || full !== (i + 1 == 16) || count !== 5'(i + 1)) bad_flags++;
        end
        n_checks++;
        if (bad_flags != 0) begin
            n_fail++;
            $display("FAIL fill_flags base=%h: %0d bad cycles want 0", base, bad_flags);
        end
        cyc(1'b1, 8'hFF, 1'b1, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || overflow !== exp_ovf || count !== 5'd16) begin
            n_fail++;
            $display("FAIL overflow_drop: got ovf=%b count=%0d want 1/16", overflow, count);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (rd_data !== exp_rd || rd_data !== base + 8'(i)) bad_data++;
        end
        n_checks++;
        if (bad_data != 0 || empty !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL drain base=%h: got %0d bad bytes empty=%b count=%0d want 0/1/0",
                     base, bad_data, empty, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf: got %b want 0", overflow);
        end
    endtask

    task automatic test_fill_overflow();
        fill_drain(8'h00);
        fill_drain(8'h10);
        // set beats clear in the same cycle
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: got %b want 1", overflow);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        while (mcount > 0) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_full_rw();
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h20 || count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw: got data=%h count=%0d full=%b ovf=%b want 20/16/1/0",
                     rd_data, count, full, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            if (rd_data !== exp_rd) bad++;
        end
        n_checks++;
        if (bad != 0 || rd_data !== 8'h77 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_rw_drain: got %0d bad, last=%h empty=%b want 0/77/1", bad, rd_data, empty);
        end
    endtask

    task automatic test_empty_rw();
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h77 || count !== 5'd1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rw: got data=%h count=%0d empty=%b want 77/1/0", rd_data, count, empty);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h5A || rd_data !== exp_rd || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_rw_pop: got data=%h empty=%b want 5a/1", rd_data, empty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (count !== 5'd7 || overflow !== 1'b1 || rd_data !== 8'h48) begin
            n_fail++;
            $display("FAIL pre_reset: got count=%0d ovf=%b data=%h want 7/1/48", count, overflow, rd_data);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (count !== 5'd0 || {empty, full, afull, overflow} !== 4'b1000 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d e/f/af/ovf=%b data=%h want 0/1000/00",
                     count, {empty, full, afull, overflow}, rd_data);
        end
        #2;
        reset = 1'b0;
        model_clear();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'h00 || empty !== 1'b1 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset_read: got data=%h empty=%b count=%0d want 00/1/0", rd_data, empty, count);
        end
    endtask

`ifdef UART_TX_FIFO_FLUSH_EN
    task automatic test_flush();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hBB;
        rd_en_n = 1'b0;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en_n = 1'b1;
        n_checks++;
        if (count !== 5'd0 || {empty, full, afull} !== 3'b100 || overflow !== 1'b1 || rd_data !== 8'h66) begin
            n_fail++;
            $display("FAIL flush: got count=%0d e/f/af=%b ovf=%b data=%h want 0/100/1/66",
                     count, {empty, full, afull}, overflow, rd_data);
        end
        sb.delete();
        mcount = 0;
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        n_checks++;
        if (rd_data !== 8'hC3 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_flush: got data=%h empty=%b want c3/1", rd_data, empty);
        end
    endtask
`endif

    initial begin
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_en_n = 1'b1;
        flush   = 1'b0;
        clr_ovf = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_async_reset();
`ifdef UART_TX_FIFO_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
